// File: rtl/des_mix_pkg.sv
// Shared defaults, FSM encoding and width helper for the key-mix serializer
// and the parallel S-box datapath that reuses key_mix_xor.
package des_mix_pkg;
  localparam int N_CHUNK_DEF = 16;
  localparam int CHUNK_W_DEF = 6;
  localparam int LANES_DEF   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Beat counter width; a single-beat block still needs a 1-bit port.
  function automatic int beat_w(input int beats);
    return (beats <= 1) ? 1 : $clog2(beats);
  endfunction
endpackage

// File: rtl/key_mix_xor.sv
// Combinational E^K split into S-box input chunks; chunk 0 is the MSB chunk,
// so the packed array read as a whole vector equals E^K.
module key_mix_xor #(
  parameter int N_CHUNK = 16,
  parameter int CHUNK_W = 6
) (
  input  logic [N_CHUNK*CHUNK_W-1:0]          e,
  input  logic [N_CHUNK*CHUNK_W-1:0]          k,
  output logic [0:N_CHUNK-1][CHUNK_W-1:0]     chunks
);
  localparam int W = N_CHUNK * CHUNK_W;

  logic [W-1:0] mix;
  assign mix = e ^ k;

  for (genvar i = 0; i < N_CHUNK; i++) begin : g_chunk
    assign chunks[i] = mix[W-1-i*CHUNK_W -: CHUNK_W];
  end
endmodule

// File: rtl/key_mix_serializer.sv
// Registers E^K once per transaction and streams it as LANES S-box chunks
// per beat over a valid/ready handshake, MSB chunk first.
module key_mix_serializer
  import des_mix_pkg::*;
#(
  parameter int N_CHUNK = N_CHUNK_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF,
  parameter int LANES   = LANES_DEF,
  localparam int W      = N_CHUNK * CHUNK_W,
  localparam int BEATS  = N_CHUNK / LANES,
  localparam int BW     = beat_w(BEATS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             E,
  input  logic [W-1:0]             K,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*CHUNK_W-1:0] out_data,
  output logic [BW-1:0]            out_beat,
  output logic                     out_last
);
  localparam int CIW = beat_w(N_CHUNK);

  if (N_CHUNK % LANES != 0) begin : g_bad_lanes
    $error("key_mix_serializer: N_CHUNK must be a multiple of LANES");
  end

  state_t                        state_q, state_d;
  logic [0:N_CHUNK-1][CHUNK_W-1:0] mix_q, mix_d;
  logic [0:N_CHUNK-1][CHUNK_W-1:0] mix_w;
  logic [BW-1:0]                 beat_q, beat_d;
  logic                          last;
  logic                          accept;
  logic [LANES*CHUNK_W-1:0]      lane_data;

  key_mix_xor #(.N_CHUNK(N_CHUNK), .CHUNK_W(CHUNK_W)) u_xor (
    .e      (E),
    .k      (K),
    .chunks (mix_w)
  );

  assign last     = (beat_q == BW'(BEATS - 1));
  // out_ready reaches in_ready so a new block can land on the last beat's edge.
  assign in_ready = !rst && ((state_q == IDLE) ||
                             ((state_q == SEND) && last && out_ready));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mix_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      mix_q   <= mix_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SEND;
      SEND:    if (out_ready && last && !in_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mix_d  = mix_q;
    beat_d = beat_q;
    if (accept) begin
      mix_d  = mix_w;
      beat_d = '0;
    end else if ((state_q == SEND) && out_ready && !last) begin
      beat_d = beat_q + BW'(1);
    end
  end

  // Lane l of the current beat carries chunk beat*LANES+l, lane 0 in the MSBs.
  always_comb begin
    lane_data = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_data[(LANES-1-l)*CHUNK_W +: CHUNK_W] =
        mix_q[CIW'(int'(beat_q) * LANES + l)];
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_beat  = '0;
    out_last  = 1'b0;
    if (state_q == SEND) begin
      out_valid = 1'b1;
      out_data  = lane_data;
      out_beat  = beat_q;
      out_last  = last;
    end
  end
endmodule

// File: tb/tb_key_mix_serializer.sv
// Scoreboard bench: default 4-lane instance plus a 16-lane single-beat instance.
module tb_key_mix_serializer;
  typedef struct {
    logic [23:0] d;
    logic [1:0]  b;
    logic        last;
  } beat4_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [95:0] E = '0, K = '0;
  logic        in_ready, out_valid, out_last;
  logic [23:0] out_data;
  logic [1:0]  out_beat;

  logic        in_valid16 = 1'b0, out_ready16 = 1'b0;
  logic [95:0] E16 = '0, K16 = '0;
  logic        in_ready16, out_valid16, out_last16;
  logic [95:0] out_data16;
  logic [0:0]  out_beat16;

  int errors = 0;
  int checks = 0;
  int seen16 = 0;
  beat4_t      q[$];
  logic [95:0] q16[$];

  always #5 clk = ~clk;

  key_mix_serializer u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .E(E), .K(K), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_beat(out_beat), .out_last(out_last)
  );

  key_mix_serializer #(.LANES(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .E(E16), .K(K16), .out_valid(out_valid16), .out_ready(out_ready16),
    .out_data(out_data16), .out_beat(out_beat16), .out_last(out_last16)
  );

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push4(input logic [95:0] e, input logic [95:0] k);
    logic [95:0] x;
    beat4_t      t;
    x = e ^ k;
    for (int b = 0; b < 4; b++) begin
      t.d    = x[95-b*24 -: 24];
      t.b    = 2'(b);
      t.last = (b == 3);
      q.push_back(t);
    end
  endtask

  initial begin : mon4
    beat4_t t;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", {93'd0, out_beat, out_last}, 96'hFFF);
        end else begin
          t = q.pop_front();
          chk("beat_data", {72'd0, out_data}, {72'd0, t.d});
          chk("beat_index", {94'd0, out_beat}, {94'd0, t.b});
          chk("beat_last", {95'd0, out_last}, {95'd0, t.last});
        end
      end
    end
  end

  initial begin : mon16
    logic [95:0] x;
    forever begin
      @(negedge clk);
      if (!rst && out_valid16 && out_ready16) begin
        seen16++;
        if (q16.size() == 0) begin
          chk("unexpected_beat16", 96'd1, 96'd0);
        end else begin
          x = q16.pop_front();
          chk("beat16_data", out_data16, x);
          chk("beat16_index", {95'd0, out_beat16}, 96'd0);
          chk("beat16_last", {95'd0, out_last16}, 96'd1);
        end
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, 96'(q.size()), 96'd0);
  endtask

  initial begin : main
    logic acc;
    int   sent;
    int   cyc;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {95'd0, out_valid}, 96'd0);
    chk("rst_out_data", {72'd0, out_data}, 96'd0);
    chk("rst_out_beat", {94'd0, out_beat}, 96'd0);
    chk("rst_out_last", {95'd0, out_last}, 96'd0);
    chk("rst_in_ready", {95'd0, in_ready}, 96'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed block with a 5-cycle stall on beat 1
    @(posedge clk); #1;
    E = 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    K = 96'hFC00_0000_0000_0000_0000_0000;
    in_valid = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", {95'd0, in_ready}, 96'd1);
    push4(E, K);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("lat_valid", {95'd0, out_valid}, 96'd1);
    chk("beat0_data", {72'd0, out_data}, 96'h03FFFF);
    chk("beat0_index", {94'd0, out_beat}, 96'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      E = {$urandom, $urandom, $urandom};
      K = {$urandom, $urandom, $urandom};
      @(negedge clk);
      chk("stall_data", {72'd0, out_data}, 96'hFFFFFF);
      chk("stall_beat", {94'd0, out_beat}, 96'd1);
      chk("stall_last", {95'd0, out_last}, 96'd0);
      chk("stall_in_ready", {95'd0, in_ready}, 96'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;   // beat 2 shown
    @(posedge clk); #1;   // beat 3 shown
    E = 96'h0;
    K = 96'h0000_0000_0000_0000_0000_003F;
    in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_last", {95'd0, out_last}, 96'd1);
    chk("b2b_in_ready", {95'd0, in_ready}, 96'd1);
    push4(E, K);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid", {95'd0, out_valid}, 96'd1);
    chk("b2b_beat0_idx", {94'd0, out_beat}, 96'd0);
    chk("b2b_beat0_data", {72'd0, out_data}, 96'h000000);
    drain("drain_b2b");

    // Reset during beat 2
    @(posedge clk); #1;
    E = 96'h1234_5678_9ABC_DEF0_1357_9BDF;
    K = 96'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
    in_valid = 1'b1;
    @(negedge clk);
    push4(E, K);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b0;
    q.delete();
    @(negedge clk);
    chk("rst_comb_in_ready", {95'd0, in_ready}, 96'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_valid", {95'd0, out_valid}, 96'd0);
    chk("mid_rst_beat", {94'd0, out_beat}, 96'd0);
    chk("mid_rst_in_ready", {95'd0, in_ready}, 96'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {95'd0, in_ready}, 96'd1);
    for (int i = 0; i < 4; i++) begin
      chk("no_stale_beat", {95'd0, out_valid}, 96'd0);
      @(negedge clk);
    end

    // Random E/K with random out_ready
    acc = 1'b0;
    sent = 0;
    cyc = 0;
    while (!(sent == 1000 && q.size() == 0) && cyc < 40000) begin
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
      if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
        E = {$urandom, $urandom, $urandom};
        K = {$urandom, $urandom, $urandom};
        in_valid = 1'b1;
      end
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) begin
        push4(E, K);
        sent++;
      end
      cyc++;
    end
    chk("random_complete", 96'(sent), 96'd1000);
    chk("random_drained", 96'(q.size()), 96'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Single-beat instance: one block per cycle
    for (int i = 0; i < 8; i++) begin
      E16 = {$urandom, $urandom, $urandom};
      K16 = {$urandom, $urandom, $urandom};
      in_valid16 = 1'b1;
      out_ready16 = 1'b1;
      @(negedge clk);
      chk("l16_in_ready", {95'd0, in_ready16}, 96'd1);
      if (i > 0) chk("l16_streaming", {95'd0, out_valid16}, 96'd1);
      q16.push_back(E16 ^ K16);
      @(posedge clk); #1;
    end
    in_valid16 = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l16_count", 96'(seen16), 96'd8);
    chk("l16_drained", 96'(q16.size()), 96'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
